heap_object_fetcher: RTL and testbench

Parametrised heap-object fetch engine for the Lisp evaluator core. It replaces the fixed inline tag/field fetch sequencer with a reusable block. Given a base address, it reads the tag word, decodes the per-tag field count (including variable-length vectors), reads every field over a fixed-latency memory port and presents the whole object to the evaluator. Errors are recoverable: on any error the block reports a code and returns to idle.

---
 rtl/heap_object_fetcher_if.sv | 38 +++
 rtl/heap_object_fetcher.sv | 179 +++++++++++++++++
 tb/tb_heap_object_fetcher.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/heap_object_fetcher_if.sv
// Request/response and memory-port bundle between the evaluator and the heap
// object fetcher.
interface heap_object_fetcher_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_FIELDS = 4
);
  localparam int unsigned CW = $clog2(MAX_FIELDS + 1);

  logic                             start;
  logic                             abort;
  logic [ADDR_WIDTH-1:0]            base_addr;
  logic                             busy;
  logic                             done;
  logic                             error;
  logic [2:0]                       err_code;
  logic [DATA_WIDTH-1:0]            obj_tag;
  logic [MAX_FIELDS*DATA_WIDTH-1:0] obj_fields;
  logic [CW-1:0]                    field_count;
  logic                             mem_re;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic [DATA_WIDTH-1:0]            mem_rdata;
  logic                             mem_err;

  // Evaluator plus heap memory side.
  modport master (
    output start, abort, base_addr, mem_rdata, mem_err,
    input  busy, done, error, err_code, obj_tag, obj_fields, field_count,
           mem_re, mem_addr
  );

  // Fetcher side.
  modport slave (
    input  start, abort, base_addr, mem_rdata, mem_err,
    output busy, done, error, err_code, obj_tag, obj_fields, field_count,
           mem_re, mem_addr
  );
endinterface

// File: rtl/heap_object_fetcher.sv
// Heap object fetch engine: reads the tag word, decodes the field count
// (vectors extend it from their length field) and reads every field.
module heap_object_fetcher #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned MAX_FIELDS    = 4,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned TAG_NUMBER    = 1,
  parameter int unsigned TAG_CONS      = 2,
  parameter int unsigned TAG_FUNC_PRIM = 3,
  parameter int unsigned TAG_FUNC      = 4,
  parameter int unsigned TAG_VECTOR    = 5
) (
  input logic clk,
  input logic rst,
  heap_object_fetcher_if.slave bus
);
  localparam int unsigned CW = $clog2(MAX_FIELDS + 1);
  localparam int unsigned LW = $clog2(READ_LATENCY + 1);
  localparam int unsigned FW = MAX_FIELDS * DATA_WIDTH;
  localparam int unsigned XW = ADDR_WIDTH + 1;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_TAG   = 3'd1;
  localparam logic [2:0] S_WAIT_FIELD = 3'd2;
  localparam logic [2:0] S_DONE       = 3'd3;
  localparam logic [2:0] S_ERR        = 3'd4;

  localparam logic [2:0] E_BAD_TAG    = 3'd1;
  localparam logic [2:0] E_MEM_ERR    = 3'd2;
  localparam logic [2:0] E_ADDR_RANGE = 3'd3;
  localparam logic [2:0] E_VEC_LEN    = 3'd4;
  localparam logic [2:0] E_ABORTED    = 3'd5;

  logic [2:0]            state_q, state_n;
  logic [ADDR_WIDTH-1:0] base_q, base_n;
  logic [DATA_WIDTH-1:0] tag_q, tag_n;
  logic [FW-1:0]         fields_q, fields_n;
  logic [CW-1:0]         count_q, count_n;
  logic [CW-1:0]         target_q, target_n;
  logic [LW-1:0]         lat_q, lat_n;
  logic [2:0]            code_q, code_n;
  logic                  busy_q, done_q, error_q;
  logic                  re_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  want_read;
  logic [XW-1:0]         addr_ext;

  // Next-state, capture and read-issue logic; reads go out combinationally
  // in the capture cycle so exactly one read is ever in flight.
  always_comb begin
    state_n   = state_q;
    base_n    = base_q;
    tag_n     = tag_q;
    fields_n  = fields_q;
    count_n   = count_q;
    target_n  = target_q;
    lat_n     = lat_q;
    code_n    = code_q;
    re_c      = 1'b0;
    addr_c    = '0;
    want_read = 1'b0;
    addr_ext  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_n   = bus.base_addr;
          fields_n = '0;
          count_n  = '0;
          code_n   = 3'd0;
          re_c     = 1'b1;
          addr_c   = bus.base_addr;
          lat_n    = LW'(1);
          state_n  = S_WAIT_TAG;
        end
      end
      S_WAIT_TAG, S_WAIT_FIELD: begin
        if (bus.abort) begin
          code_n  = E_ABORTED;
          state_n = S_ERR;
        end else if (bus.mem_err) begin
          code_n  = E_MEM_ERR;
          state_n = S_ERR;
        end else if (lat_q != LW'(READ_LATENCY)) begin
          lat_n = lat_q + LW'(1);
        end else if (state_q == S_WAIT_TAG) begin
          tag_n     = bus.mem_rdata;
          want_read = 1'b1;
          if (bus.mem_rdata == DATA_WIDTH'(TAG_NUMBER) ||
              bus.mem_rdata == DATA_WIDTH'(TAG_FUNC_PRIM) ||
              bus.mem_rdata == DATA_WIDTH'(TAG_VECTOR)) begin
            target_n = CW'(1);
          end else if (bus.mem_rdata == DATA_WIDTH'(TAG_CONS)) begin
            target_n = CW'(2);
          end else if (bus.mem_rdata == DATA_WIDTH'(TAG_FUNC)) begin
            target_n = CW'(3);
          end else begin
            want_read = 1'b0;
            code_n    = E_BAD_TAG;
            state_n   = S_ERR;
          end
        end else begin
          for (int i = 0; i < int'(MAX_FIELDS); i++) begin
            if (CW'(i) == count_q) fields_n[i*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
          end
          count_n   = count_q + CW'(1);
          want_read = 1'b1;
          // A vector's first field is its element count.
          if (tag_q == DATA_WIDTH'(TAG_VECTOR) && count_q == '0) begin
            if (bus.mem_rdata > DATA_WIDTH'(MAX_FIELDS - 1)) begin
              want_read = 1'b0;
              code_n    = E_VEC_LEN;
              state_n   = S_ERR;
            end else begin
              target_n = CW'(bus.mem_rdata) + CW'(1);
            end
          end
          if (want_read && count_n == target_n) begin
            want_read = 1'b0;
            state_n   = S_DONE;
          end
        end
        if (want_read) begin
          addr_ext = {1'b0, base_q} + XW'(1) + XW'(count_n);
          if (addr_ext[ADDR_WIDTH]) begin
            code_n  = E_ADDR_RANGE;
            state_n = S_ERR;
          end else begin
            re_c    = 1'b1;
            addr_c  = addr_ext[ADDR_WIDTH-1:0];
            lat_n   = LW'(1);
            state_n = S_WAIT_FIELD;
          end
        end
      end
      S_DONE, S_ERR: state_n = S_IDLE;
      default:       state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any fetch in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      tag_q    <= '0;
      fields_q <= '0;
      count_q  <= '0;
      target_q <= '0;
      lat_q    <= '0;
      code_q   <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      base_q   <= base_n;
      tag_q    <= tag_n;
      fields_q <= fields_n;
      count_q  <= count_n;
      target_q <= target_n;
      lat_q    <= lat_n;
      code_q   <= code_n;
      busy_q   <= (state_n == S_WAIT_TAG) || (state_n == S_WAIT_FIELD);
      done_q   <= (state_n == S_DONE);
      error_q  <= (state_n == S_ERR);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.err_code    = code_q;
  assign bus.obj_tag     = tag_q;
  assign bus.obj_fields  = fields_q;
  assign bus.field_count = count_q;
  assign bus.mem_re      = re_c;
  assign bus.mem_addr    = addr_c;
endmodule

// File: tb/tb_heap_object_fetcher.sv
// Bench for heap_object_fetcher: two instances (read latency 2 and 1) run the
// same directed fetches against a transaction-level model of each object.
module tb_heap_object_fetcher;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  start_v = 2'b00;
  logic        abort_v = 1'b0;
  logic        merr_v  = 1'b0;
  logic [15:0] base_v  = 16'h0000;

  heap_object_fetcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_FIELDS(MF)) ifa ();
  heap_object_fetcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_FIELDS(MF)) ifb ();

  heap_object_fetcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_FIELDS(MF), .READ_LATENCY(2))
    dut0 (.clk(clk), .rst(rst), .bus(ifa));
  heap_object_fetcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_FIELDS(MF), .READ_LATENCY(1))
    dut1 (.clk(clk), .rst(rst), .bus(ifb));

  logic [15:0] mem [0:65535];
  logic        v0_s1 = 1'b0, v0_s2 = 1'b0, v1_s1 = 1'b0;
  logic [15:0] a0_s1 = 16'h0, a0_s2 = 16'h0, a1_s1 = 16'h0;
  int          cyc = 0;

  assign ifa.start     = start_v[0];
  assign ifb.start     = start_v[1];
  assign ifa.abort     = abort_v;
  assign ifb.abort     = abort_v;
  assign ifa.mem_err   = merr_v;
  assign ifb.mem_err   = merr_v;
  assign ifa.base_addr = base_v;
  assign ifb.base_addr = base_v;
  assign ifa.mem_rdata = v0_s2 ? mem[a0_s2] : 16'hDEAD;
  assign ifb.mem_rdata = v1_s1 ? mem[a1_s1] : 16'hDEAD;

  // Fixed-latency memory: a read strobed in cycle t returns in cycle t+latency.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    v0_s1 <= ifa.mem_re;  a0_s1 <= ifa.mem_addr;
    v0_s2 <= v0_s1;       a0_s2 <= a0_s1;
    v1_s1 <= ifb.mem_re;  a1_s1 <= ifb.mem_addr;
  end

  int total = 0;
  int bad   = 0;

  int          rl_of [2] = '{2, 1};
  int          e_end [2];
  bit          e_err [2];
  logic [2:0]  e_code[2];
  logic [15:0] e_tag [2];
  logic [63:0] e_fld [2];
  int          e_cnt [2];
  int          e_nr  [2];
  int          e_rc  [2][8];
  logic [15:0] e_ra  [2][8];
  logic [15:0] tag_hold[2] = '{16'h0, 16'h0};
  bit          chk_en = 1'b0;
  int          t0 = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Walks the object as a sequence of reads; each capture lands `rl` cycles
  // after its read and an abort/mem_err in a busy cycle ends the fetch.
  task automatic model(input int d, input logic [15:0] base, input int ab, input int me);
    int rl = rl_of[d];
    int t = 0;
    int c;
    int n = 0;
    bit tagph = 1'b1;
    logic [16:0] nx;
    logic [15:0] data;
    logic [15:0] last;
    logic [63:0] f = 64'h0;
    e_nr[d] = 1; e_rc[d][0] = 0; e_ra[d][0] = base; last = base;
    e_cnt[d] = 0; e_code[d] = 3'd0; e_err[d] = 1'b0; e_tag[d] = tag_hold[d];
    while (1) begin
      c = t + rl;
      if (ab >= 1 && ab <= c && !(me >= 1 && me < ab)) begin
        e_err[d] = 1; e_code[d] = 3'd5; e_end[d] = ab + 1; break;
      end
      if (me >= 1 && me <= c) begin
        e_err[d] = 1; e_code[d] = 3'd2; e_end[d] = me + 1; break;
      end
      data = mem[last];
      e_end[d] = c + 1;
      if (tagph) begin
        e_tag[d] = data;
        case (data)
          16'd1, 16'd3, 16'd5: n = 1;
          16'd2:               n = 2;
          16'd4:               n = 3;
          default:             n = 0;
        endcase
        if (n == 0) begin e_err[d] = 1; e_code[d] = 3'd1; break; end
        tagph = 1'b0;
      end else begin
        f[e_cnt[d]*16 +: 16] = data;
        e_cnt[d]++;
        if (e_tag[d] == 16'd5 && e_cnt[d] == 1) begin
          if (data > 16'(MF - 1)) begin e_err[d] = 1; e_code[d] = 3'd4; break; end
          n = 1 + int'(data);
        end
        if (e_cnt[d] == n) break;
      end
      nx = {1'b0, base} + 17'd1 + 17'(e_cnt[d]);
      if (nx > 17'h0FFFF) begin e_err[d] = 1; e_code[d] = 3'd3; break; end
      e_rc[d][e_nr[d]] = c; e_ra[d][e_nr[d]] = nx[15:0]; e_nr[d]++;
      last = nx[15:0]; t = c;
    end
    e_fld[d] = f;
    tag_hold[d] = e_tag[d];
  endtask

  task automatic cmp(input int d, input logic re, input logic [15:0] ad, input logic bz,
                     input logic dn, input logic er, input logic [2:0] cd,
                     input logic [15:0] tg, input logic [63:0] fl, input logic [2:0] fc);
    int rel = cyc - t0;
    logic xre = 1'b0;
    logic [15:0] xad = 16'h0;
    for (int i = 0; i < e_nr[d]; i++)
      if (e_rc[d][i] == rel) begin xre = 1'b1; xad = e_ra[d][i]; end
    check($sformatf("d%0d@%0d mem_re", d, rel), 64'(re), 64'(xre));
    check($sformatf("d%0d@%0d mem_addr", d, rel), 64'(ad), 64'(xad));
    check($sformatf("d%0d@%0d busy", d, rel), 64'(bz), 64'(rel >= 1 && rel < e_end[d]));
    check($sformatf("d%0d@%0d done", d, rel), 64'(dn), 64'(rel == e_end[d] && !e_err[d]));
    check($sformatf("d%0d@%0d error", d, rel), 64'(er), 64'(rel == e_end[d] && e_err[d]));
    if (rel >= e_end[d]) begin
      check($sformatf("d%0d@%0d err_code", d, rel), 64'(cd), 64'(e_code[d]));
      check($sformatf("d%0d@%0d obj_tag", d, rel), 64'(tg), 64'(e_tag[d]));
      check($sformatf("d%0d@%0d obj_fields", d, rel), fl, e_fld[d]);
      check($sformatf("d%0d@%0d field_count", d, rel), 64'(fc), 64'(e_cnt[d]));
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, ifa.mem_re, ifa.mem_addr, ifa.busy, ifa.done, ifa.error, ifa.err_code,
          ifa.obj_tag, ifa.obj_fields, ifa.field_count);
      cmp(1, ifb.mem_re, ifb.mem_addr, ifb.busy, ifb.done, ifb.error, ifb.err_code,
          ifb.obj_tag, ifb.obj_fields, ifb.field_count);
    end
  end

  task automatic run(input logic [15:0] base, input int ab, input int me, input bit stray);
    int mx;
    @(posedge clk); #1;
    model(0, base, ab, me);
    model(1, base, ab, me);
    mx = (e_end[0] > e_end[1]) ? e_end[0] : e_end[1];
    t0 = cyc;
    chk_en = 1'b1;
    for (int r = 0; r <= mx; r++) begin
      if (r > 0) begin @(posedge clk); #1; end
      for (int d = 0; d < 2; d++)
        start_v[d] = (r == 0) || (stray && (r == 1 || r == e_end[d]));
      base_v  = (r == 0) ? base : 16'h0040;
      abort_v = (r == ab);
      merr_v  = (r == me);
    end
  endtask

  task automatic zero_chk(input string nm, input int d);
    logic [63:0] acc;
    if (d == 0)
      acc = {ifa.obj_fields} | 64'(ifa.obj_tag) | 64'(ifa.err_code) | 64'(ifa.field_count)
          | 64'(ifa.mem_addr) | 64'({ifa.busy, ifa.done, ifa.error, ifa.mem_re});
    else
      acc = {ifb.obj_fields} | 64'(ifb.obj_tag) | 64'(ifb.err_code) | 64'(ifb.field_count)
          | 64'(ifb.mem_addr) | 64'({ifb.busy, ifb.done, ifb.error, ifb.mem_re});
    check(nm, acc, 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'd1; mem[16'h0011] = 16'h002A;
    mem[16'h0020] = 16'd2; mem[16'h0021] = 16'h0030; mem[16'h0022] = 16'h0040;
    mem[16'h0030] = 16'd5; mem[16'h0031] = 16'd2; mem[16'h0032] = 16'hAAAA; mem[16'h0033] = 16'hBBBB;
    mem[16'h0040] = 16'd5; mem[16'h0041] = 16'd0;
    mem[16'h0050] = 16'd5; mem[16'h0051] = 16'd4;
    mem[16'h0060] = 16'd7;
    mem[16'h0070] = 16'd4; mem[16'h0071] = 16'h1111; mem[16'h0072] = 16'h2222; mem[16'h0073] = 16'h3333;
    mem[16'h0080] = 16'd3; mem[16'h0081] = 16'h9999;
    mem[16'hFFFE] = 16'd2; mem[16'hFFFF] = 16'h1234;
    mem[16'h0000] = 16'hBAD0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_chk("reset_state_d0", 0);
    zero_chk("reset_state_d1", 1);
    @(posedge clk); #1 rst = 1'b0;

    run(16'h0010, -1, -1, 1'b1);
    check("pin_number_done_cycle", 64'(e_end[0]), 64'd5);
    check("pin_number_second_read", 64'(e_rc[0][1]), 64'd2);
    check("pin_number_field0", ifa.obj_fields, 64'h002A);
    run(16'h0020, -1, -1, 1'b0);
    check("pin_cons_done_rl2", 64'(e_end[0]), 64'd7);
    check("pin_cons_done_rl1", 64'(e_end[1]), 64'd4);
    run(16'h0030, -1, -1, 1'b1);
    check("pin_vector_fields", ifa.obj_fields, 64'h0000_BBBB_AAAA_0002);
    check("pin_vector_count", 64'(ifa.field_count), 64'd3);
    run(16'h0040, -1, -1, 1'b0);
    run(16'h0050, -1, -1, 1'b1);
    check("pin_veclen_reads", 64'(e_nr[0]), 64'd2);
    run(16'h0060, -1, -1, 1'b1);
    check("pin_badtag_err_cycle", 64'(e_end[0]), 64'd3);
    check("pin_badtag_reads", 64'(e_nr[0]), 64'd1);
    run(16'hFFFE, -1, -1, 1'b0);
    check("pin_range_code", 64'(ifa.err_code), 64'd3);
    run(16'h0070, -1, 3, 1'b0);
    check("pin_memerr_cycle", 64'(e_end[0]), 64'd4);
    run(16'h0070, -1, -1, 1'b1);
    run(16'h0070, 3, -1, 1'b0);
    run(16'h0070, 4, 4, 1'b0);
    run(16'h0080, -1, -1, 1'b0);

    // Reset in the middle of a field read wipes everything silently.
    @(posedge clk); #1;
    chk_en = 1'b0;
    start_v = 2'b11; base_v = 16'h0070; abort_v = 1'b0; merr_v = 1'b0;
    @(posedge clk); #1 start_v = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tag_hold = '{16'h0, 16'h0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      zero_chk($sformatf("post_reset_quiet_d0_%0d", k), 0);
      zero_chk($sformatf("post_reset_quiet_d1_%0d", k), 1);
    end

    run(16'h0010, -1, -1, 1'b0);
    @(posedge clk); #1;
    chk_en = 1'b0; start_v = 2'b00; abort_v = 1'b0; merr_v = 1'b0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
